// File: rtl/vscale_alu_arbiter_pkg.sv
// Shared widths, ALU op codes and arbiter state encoding for the vscale ALU arbiter.
package vscale_alu_arbiter_pkg;

  localparam int XPR_LEN = 32;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'd10;

  localparam int ARB_STATE_WIDTH = 1;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vscale_alu_arbiter_if.sv
// Auxiliary requester <-> ALU arbiter handshake: request payload in, held result out.
interface vscale_alu_arbiter_if;
  import vscale_alu_arbiter_pkg::*;

  logic                    aux_req_valid;
  logic                    aux_req_ready;
  logic [XPR_LEN-1:0]      aux_op_a;
  logic [XPR_LEN-1:0]      aux_op_b;
  logic [ALU_OP_WIDTH-1:0] aux_alu_op;
  logic                    aux_resp_valid;
  logic                    aux_resp_ready;
  logic [XPR_LEN-1:0]      aux_resp_data;

  modport master (
    output aux_req_valid, aux_op_a, aux_op_b, aux_alu_op, aux_resp_ready,
    input  aux_req_ready, aux_resp_valid, aux_resp_data
  );

  modport slave (
    input  aux_req_valid, aux_op_a, aux_op_b, aux_alu_op, aux_resp_ready,
    output aux_req_ready, aux_resp_valid, aux_resp_data
  );

endinterface

// File: rtl/vscale_alu_arbiter_starve_ctr.sv
// Saturating count of cycles an auxiliary request has been refused; flags when MAX_WAIT is reached.
module vscale_alu_arbiter_starve_ctr #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic starve_force
);

  localparam logic [7:0] WaitLimit = 8'(MAX_WAIT);

  logic [7:0] cnt;

  // Clear has priority so a grant or a withdrawn request always restarts the wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (count_en && (cnt != WaitLimit)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign starve_force = (cnt == WaitLimit);

endmodule

// File: rtl/vscale_alu_arbiter.sv
// Time-shares the ALU between the DX stage and one auxiliary requester.
// Define VSCALE_ALU_ARB_ANTISTARVE_EN to add the forced-grant / DX-stall anti-starvation path.
module vscale_alu_arbiter
  import vscale_alu_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dx_alu_busy,
  input  logic [XPR_LEN-1:0]      dx_src_a,
  input  logic [XPR_LEN-1:0]      dx_src_b,
  input  logic [ALU_OP_WIDTH-1:0] dx_alu_op,
  output logic [XPR_LEN-1:0]      alu_src_a,
  output logic [XPR_LEN-1:0]      alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [XPR_LEN-1:0]      alu_out,
  vscale_alu_arbiter_if.slave     aux,
  output logic                    arb_stall_DX
);

  arb_state_e         state;
  logic [XPR_LEN-1:0] resp_data;
  logic               grant_aux;
  logic               starve_force;

  assign grant_aux = (state == ARB_IDLE) && aux.aux_req_valid && (!dx_alu_busy || starve_force);

  assign aux.aux_req_ready  = grant_aux;
  assign aux.aux_resp_valid = (state == ARB_RESP);
  assign aux.aux_resp_data  = resp_data;

  assign alu_src_a = grant_aux ? aux.aux_op_a   : dx_src_a;
  assign alu_src_b = grant_aux ? aux.aux_op_b   : dx_src_b;
  assign alu_op    = grant_aux ? aux.aux_alu_op : dx_alu_op;

  // The result is captured only on the grant edge, so later pipeline ALU traffic cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      resp_data <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_aux) begin
            state     <= ARB_RESP;
            resp_data <= alu_out;
          end
        end
        ARB_RESP: begin
          if (aux.aux_resp_ready) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef VSCALE_ALU_ARB_ANTISTARVE_EN
  logic count_en;
  logic count_clear;

  assign count_en    = (state == ARB_IDLE) && aux.aux_req_valid && !grant_aux;
  assign count_clear = grant_aux || !aux.aux_req_valid;

  vscale_alu_arbiter_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk          (clk),
    .reset        (reset),
    .count_en     (count_en),
    .clear        (count_clear),
    .starve_force (starve_force)
  );

  // A grant while DX is busy can only be a forced one; DX must hold and replay its op.
  assign arb_stall_DX = grant_aux && dx_alu_busy;
`else
  assign starve_force = 1'b0;
  assign arb_stall_DX = 1'b0;
`endif

endmodule

// File: tb/tb_vscale_alu_arbiter.sv
// Self-checking bench for vscale_alu_arbiter; follows VSCALE_ALU_ARB_ANTISTARVE_EN when defined.
module tb_vscale_alu_arbiter;
  import vscale_alu_arbiter_pkg::*;

  localparam int MAX_WAIT = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    dx_alu_busy;
  logic [XPR_LEN-1:0]      dx_src_a;
  logic [XPR_LEN-1:0]      dx_src_b;
  logic [ALU_OP_WIDTH-1:0] dx_alu_op;
  logic [XPR_LEN-1:0]      alu_src_a;
  logic [XPR_LEN-1:0]      alu_src_b;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [XPR_LEN-1:0]      alu_out;
  logic                    arb_stall_DX;

  int total = 0;
  int bad   = 0;

  vscale_alu_arbiter_if aux ();

  vscale_alu_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .dx_alu_busy  (dx_alu_busy),
    .dx_src_a     (dx_src_a),
    .dx_src_b     (dx_src_b),
    .dx_alu_op    (dx_alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .aux          (aux.slave),
    .arb_stall_DX (arb_stall_DX)
  );

  always #5 clk = ~clk;

  function automatic logic [XPR_LEN-1:0] alu_f(input logic [XPR_LEN-1:0] a, input logic [XPR_LEN-1:0] b,
                                               input logic [ALU_OP_WIDTH-1:0] op);
    case (op)
      ALU_OP_SUB: return a - b;
      ALU_OP_XOR: return a ^ b;
      ALU_OP_OR:  return a | b;
      ALU_OP_AND: return a & b;
      default:    return a + b;
    endcase
  endfunction

  // Behavioural ALU sitting behind the arbiter.
  assign alu_out = alu_f(alu_src_a, alu_src_b, alu_op);

  function automatic logic [ALU_OP_WIDTH-1:0] random_op();
    logic [ALU_OP_WIDTH-1:0] ops [5];
    ops = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_XOR, ALU_OP_OR, ALU_OP_AND};
    return ops[$urandom_range(0, 4)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    dx_alu_busy        = 1'b0;
    dx_src_a           = $urandom;
    dx_src_b           = $urandom;
    dx_alu_op          = random_op();
    aux.aux_req_valid  = 1'b0;
    aux.aux_op_a       = '0;
    aux.aux_op_b       = '0;
    aux.aux_alu_op     = ALU_OP_ADD;
    aux.aux_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    step();
    total++;
    if (aux.aux_resp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_resp_valid got=%0b want=0", aux.aux_resp_valid);
    end
    total++;
    if (aux.aux_resp_data !== '0) begin
      bad++; $display("[TB] FAIL reset_resp_data got=%0h want=0", aux.aux_resp_data);
    end
    total++;
    if (aux.aux_req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_req_ready got=%0b want=0", aux.aux_req_ready);
    end
    total++;
    if (arb_stall_DX !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_stall got=%0b want=0", arb_stall_DX);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_add_grant();
    dx_src_a          = 32'd100;
    aux.aux_req_valid = 1'b1;
    aux.aux_op_a      = 32'd5;
    aux.aux_op_b      = 32'd3;
    aux.aux_alu_op    = ALU_OP_ADD;
    #1;
    total++;
    if (aux.aux_req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL add_req_ready got=%0b want=1", aux.aux_req_ready);
    end
    total++;
    if (alu_src_a !== 32'd5) begin
      bad++; $display("[TB] FAIL add_alu_src_a got=%0d want=5", alu_src_a);
    end
    step();
    aux.aux_req_valid = 1'b0;
    #1;
    total++;
    if (aux.aux_resp_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL add_resp_valid got=%0b want=1", aux.aux_resp_valid);
    end
    total++;
    if (aux.aux_resp_data !== 32'd8) begin
      bad++; $display("[TB] FAIL add_resp_data got=%0d want=8", aux.aux_resp_data);
    end
    aux.aux_resp_ready = 1'b1;
    step();
    aux.aux_resp_ready = 1'b0;
    #1;
    total++;
    if (aux.aux_resp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL add_resp_release got=%0b want=0", aux.aux_resp_valid);
    end
  endtask

`ifdef VSCALE_ALU_ARB_ANTISTARVE_EN
  // Two rounds: the second proves the wait count restarted from zero after the forced grant.
  task automatic test_starve();
    logic [XPR_LEN-1:0] exp_data;
    logic               exp_grant;
    dx_alu_busy = 1'b1;
    for (int r = 0; r < 2; r++) begin
      aux.aux_req_valid = 1'b1;
      aux.aux_op_a      = $urandom;
      aux.aux_op_b      = $urandom;
      aux.aux_alu_op    = random_op();
      exp_data          = alu_f(aux.aux_op_a, aux.aux_op_b, aux.aux_alu_op);
      for (int k = 1; k <= MAX_WAIT + 1; k++) begin
        dx_src_a  = $urandom;
        exp_grant = (k == MAX_WAIT + 1);
        #1;
        total++;
        if (aux.aux_req_ready !== exp_grant) begin
          bad++; $display("[TB] FAIL starve_ready r=%0d k=%0d got=%0b want=%0b", r, k, aux.aux_req_ready, exp_grant);
        end
        total++;
        if (arb_stall_DX !== exp_grant) begin
          bad++; $display("[TB] FAIL starve_stall r=%0d k=%0d got=%0b want=%0b", r, k, arb_stall_DX, exp_grant);
        end
        total++;
        if (alu_src_a !== (exp_grant ? aux.aux_op_a : dx_src_a)) begin
          bad++; $display("[TB] FAIL starve_src_a r=%0d k=%0d got=%0h", r, k, alu_src_a);
        end
        step();
      end
      aux.aux_resp_ready = 1'b1;
      #1;
      total++;
      if (aux.aux_resp_data !== exp_data || aux.aux_resp_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL starve_resp r=%0d got=%0h/%0b want=%0h/1", r, aux.aux_resp_data, aux.aux_resp_valid, exp_data);
      end
      total++;
      if (arb_stall_DX !== 1'b0) begin
        bad++; $display("[TB] FAIL starve_stall_after r=%0d got=%0b want=0", r, arb_stall_DX);
      end
      step();
      aux.aux_resp_ready = 1'b0;
    end
    drive_idle();
    step();
  endtask
`else
  task automatic test_starve();
    dx_alu_busy       = 1'b1;
    aux.aux_req_valid = 1'b1;
    aux.aux_op_a      = $urandom;
    aux.aux_op_b      = $urandom;
    for (int k = 0; k < 20; k++) begin
      dx_src_a = $urandom;
      #1;
      total++;
      if (aux.aux_req_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL busy_ready k=%0d got=%0b want=0", k, aux.aux_req_ready);
      end
      total++;
      if (alu_src_a !== dx_src_a) begin
        bad++; $display("[TB] FAIL busy_src_a k=%0d got=%0h want=%0h", k, alu_src_a, dx_src_a);
      end
      total++;
      if (arb_stall_DX !== 1'b0) begin
        bad++; $display("[TB] FAIL busy_stall k=%0d got=%0b want=0", k, arb_stall_DX);
      end
      step();
    end
    drive_idle();
    step();
  endtask
`endif

  task automatic test_hold_response();
    logic [XPR_LEN-1:0] exp_data;
    aux.aux_req_valid = 1'b1;
    aux.aux_op_a      = $urandom;
    aux.aux_op_b      = $urandom;
    aux.aux_alu_op    = ALU_OP_XOR;
    exp_data          = aux.aux_op_a ^ aux.aux_op_b;
    step();
    dx_alu_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dx_src_a       = $urandom;
      dx_src_b       = $urandom;
      dx_alu_op      = random_op();
      aux.aux_op_a   = $urandom;
      #1;
      total++;
      if (aux.aux_resp_data !== exp_data) begin
        bad++; $display("[TB] FAIL hold_data k=%0d got=%0h want=%0h", k, aux.aux_resp_data, exp_data);
      end
      total++;
      if (aux.aux_req_ready !== 1'b0 || aux.aux_resp_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL hold_handshake k=%0d got ready=%0b valid=%0b want 0/1", k, aux.aux_req_ready, aux.aux_resp_valid);
      end
      step();
    end
    aux.aux_req_valid  = 1'b0;
    aux.aux_resp_ready = 1'b1;
    step();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [XPR_LEN-1:0] exp_data [4];
    dx_alu_busy        = 1'b0;
    aux.aux_req_valid  = 1'b1;
    aux.aux_resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        aux.aux_op_a    = $urandom;
        aux.aux_op_b    = $urandom;
        aux.aux_alu_op  = random_op();
        exp_data[c / 2] = alu_f(aux.aux_op_a, aux.aux_op_b, aux.aux_alu_op);
      end
      dx_src_a = $urandom;
      #1;
      total++;
      if (aux.aux_req_ready !== (c % 2 == 0)) begin
        bad++; $display("[TB] FAIL b2b_ready c=%0d got=%0b want=%0b", c, aux.aux_req_ready, (c % 2 == 0));
      end
      total++;
      if (aux.aux_resp_valid !== (c % 2 == 1)) begin
        bad++; $display("[TB] FAIL b2b_resp_valid c=%0d got=%0b want=%0b", c, aux.aux_resp_valid, (c % 2 == 1));
      end
      if (c % 2 == 1) begin
        total++;
        if (aux.aux_resp_data !== exp_data[c / 2]) begin
          bad++; $display("[TB] FAIL b2b_data c=%0d got=%0h want=%0h", c, aux.aux_resp_data, exp_data[c / 2]);
        end
      end
      step();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_response();
    aux.aux_req_valid = 1'b1;
    aux.aux_op_a      = 32'hdead_0000;
    aux.aux_op_b      = 32'h0000_beef;
    aux.aux_alu_op    = ALU_OP_OR;
    step();
    total++;
    if (aux.aux_resp_valid !== 1'b1 || aux.aux_resp_data !== 32'hdead_beef) begin
      bad++; $display("[TB] FAIL midrst_pre got=%0b/%0h want=1/deadbeef", aux.aux_resp_valid, aux.aux_resp_data);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (aux.aux_resp_valid !== 1'b0 || aux.aux_resp_data !== '0) begin
      bad++; $display("[TB] FAIL midrst_async got=%0b/%0h want=0/0", aux.aux_resp_valid, aux.aux_resp_data);
    end
    step();
    reset = 1'b0;
    aux.aux_op_a = 32'd7;
    aux.aux_op_b = 32'd2;
    aux.aux_alu_op = ALU_OP_SUB;
    #1;
    total++;
    if (aux.aux_req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_idle_grant got=%0b want=1", aux.aux_req_ready);
    end
    step();
    aux.aux_req_valid  = 1'b0;
    aux.aux_resp_ready = 1'b1;
    #1;
    total++;
    if (aux.aux_resp_data !== 32'd5) begin
      bad++; $display("[TB] FAIL midrst_next_data got=%0d want=5", aux.aux_resp_data);
    end
    step();
    drive_idle();
  endtask

  // Reference model: one outstanding result, plus a count of consecutive refused cycles.
  task automatic test_random();
    bit                      pend = 0;
    bit                      forced;
    bit                      exp_grant;
    int                      waited = 0;
    logic [XPR_LEN-1:0]      last_data = '0;
    logic [XPR_LEN-1:0]      exp_a, exp_b;
    logic [ALU_OP_WIDTH-1:0] exp_op;
    reset = 1'b1;
    drive_idle();
    step();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      dx_alu_busy        = ($urandom_range(0, 3) != 0);
      aux.aux_req_valid  = ($urandom_range(0, 3) != 0);
      aux.aux_op_a       = $urandom;
      aux.aux_op_b       = $urandom;
      aux.aux_alu_op     = random_op();
      aux.aux_resp_ready = ($urandom_range(0, 1) == 1);
      dx_src_a           = $urandom;
      dx_src_b           = $urandom;
      dx_alu_op          = random_op();
      #1;
      forced = 1'b0;
`ifdef VSCALE_ALU_ARB_ANTISTARVE_EN
      forced = (waited >= MAX_WAIT);
`endif
      exp_grant = !pend && aux.aux_req_valid && (!dx_alu_busy || forced);
      exp_a  = exp_grant ? aux.aux_op_a   : dx_src_a;
      exp_b  = exp_grant ? aux.aux_op_b   : dx_src_b;
      exp_op = exp_grant ? aux.aux_alu_op : dx_alu_op;
      total++;
      if (aux.aux_req_ready !== exp_grant) begin
        bad++; $display("[TB] FAIL rnd_ready c=%0d got=%0b want=%0b", c, aux.aux_req_ready, exp_grant);
      end
      total++;
      if (alu_src_a !== exp_a || alu_src_b !== exp_b || alu_op !== exp_op) begin
        bad++; $display("[TB] FAIL rnd_alu_in c=%0d got=%0h,%0h,%0h want=%0h,%0h,%0h", c, alu_src_a, alu_src_b, alu_op, exp_a, exp_b, exp_op);
      end
      total++;
      if (arb_stall_DX !== (exp_grant && dx_alu_busy)) begin
        bad++; $display("[TB] FAIL rnd_stall c=%0d got=%0b want=%0b", c, arb_stall_DX, (exp_grant && dx_alu_busy));
      end
      total++;
      if (aux.aux_resp_valid !== pend) begin
        bad++; $display("[TB] FAIL rnd_resp_valid c=%0d got=%0b want=%0b", c, aux.aux_resp_valid, pend);
      end
      total++;
      if (aux.aux_resp_data !== last_data) begin
        bad++; $display("[TB] FAIL rnd_resp_data c=%0d got=%0h want=%0h", c, aux.aux_resp_data, last_data);
      end
      if (exp_grant) begin
        pend      = 1'b1;
        last_data = alu_f(aux.aux_op_a, aux.aux_op_b, aux.aux_alu_op);
        waited    = 0;
      end else if (!aux.aux_req_valid) begin
        waited = 0;
        if (pend && aux.aux_resp_ready) pend = 1'b0;
      end else if (pend) begin
        if (aux.aux_resp_ready) pend = 1'b0;
      end else if (waited < MAX_WAIT) begin
        waited++;
      end
      step();
    end
    drive_idle();
    aux.aux_resp_ready = 1'b1;
    step();
    aux.aux_resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_add_grant();
    test_starve();
    test_hold_response();
    test_back_to_back();
    test_reset_mid_response();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
